cache_refill_ctrl: RTL and testbench
====================================

CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the address width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the data and beat width in bits; BYTES = DATA_WIDTH/8.
REQ-003 SHALL have parameter LINE_SIZE_BITS, default 7, log2 of the cache line size in bytes; BEATS = 2^LINE_SIZE_BITS / BYTES (32 at defaults).
REQ-004 SHALL have the port list below; one clock; reset is synchronous and active-high.
- clk  in  1  sole clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- miss  in  1  cache miss flag; high until the cache consumes mem_last.
- cpu_addr  in  ADDR_WIDTH  missing CPU address.
- arvalid / arready  out / in  1  AXI read-address handshake.
- araddr  out  ADDR_WIDTH  line-aligned burst address.
- arlen  out  8  BEATS-1.
- arsize  out  3  log2(BYTES).
- arburst  out  2  constant 2'b01 (INCR).
- rvalid / rready  in / out  1  AXI read-data handshake.
- rdata  in  DATA_WIDTH  read beat.
- rresp  in  2  beat response.
- rlast  in  1  final beat of the burst.
- mem_addr  out  ADDR_WIDTH  byte address of the beat presented to the cache.
- mem_data_in  out  DATA_WIDTH  beat data to the cache.
- mem_wstb  out  BYTES  beat strobes; all ones whenever mem_data_valid is high.
- mem_data_valid  out  1  one-cycle pulse per beat.
- mem_last  out  1  qualifies the final beat; high only together with mem_data_valid.
- busy  out  1  high in every state other than IDLE.
- err  out  1  sticky error flag.
- refill_cnt  out  16  count of completed refills; saturates at 0xFFFF.

Function
REQ-005 SHALL implement four states: IDLE, ADDR, DATA, DONE.
REQ-006 IDLE: when miss=1, SHALL latch line_base = cpu_addr with bits [LINE_SIZE_BITS-1:0] cleared, clear the beat counter, and go to ADDR; arvalid=1 on the next cycle.
REQ-007 ADDR: SHALL hold arvalid=1 and stable araddr=line_base, arlen, arsize, arburst until arvalid&&arready; on that edge SHALL drop arvalid and go to DATA.
REQ-008 DATA: SHALL drive rready=1; rready SHALL be 0 in every other state.
REQ-009 DATA, each edge with rvalid&&rready: SHALL register mem_data_in=rdata, mem_addr=line_base+beat*BYTES, mem_data_valid=1 for exactly the following cycle, and increment beat (width LINE_SIZE_BITS, no wrap within a burst).
REQ-010 Beat latency SHALL be 1 cycle from rvalid&&rready to mem_data_valid; rvalid gaps SHALL produce no mem_data_valid pulse.
REQ-011 mem_last SHALL be 1 on the beat where beat==BEATS-1 or rlast=1, whichever comes first; that beat SHALL move the FSM to DONE.
REQ-012 Early rlast (beat<BEATS-1) SHALL set err and still complete via mem_last; rlast=0 on beat BEATS-1 SHALL set err; beats after DONE SHALL be ignored (rready=0).
REQ-013 rresp!=2'b00 on any accepted beat SHALL set err; data SHALL still be forwarded.
REQ-014 err SHALL be cleared only by reset.
REQ-015 DONE: SHALL wait until miss=0, then increment refill_cnt (saturating) and return to IDLE; a miss still high in DONE SHALL NOT start a new burst.
REQ-016 cpu_addr changes after the IDLE latch SHALL NOT affect araddr or mem_addr.
REQ-017 busy SHALL equal (state!=IDLE).

Reset
REQ-018 reset=1 at any edge, including mid-burst, SHALL force IDLE and, on the next cycle, arvalid=0, rready=0, mem_data_valid=0, mem_last=0, mem_wstb=0, mem_addr=0, mem_data_in=0, busy=0, err=0, refill_cnt=0.
REQ-019 After a mid-burst reset, outstanding R beats SHALL NOT be forwarded; the next miss SHALL start a fresh burst.

Verification
REQ-020 miss=1, cpu_addr=0x0000_1234, arready=1, 32 back-to-back OKAY beats with rdata=beat index -> araddr=0x0000_1200, arlen=31, arsize=2, arburst=1; 32 mem_data_valid pulses, mem_addr 0x1200..0x127C, mem_last only on the 32nd; refill_cnt=1 after miss drops.
REQ-021 arready held 0 for 3 cycles -> arvalid and araddr stable for 4 cycles; the burst then completes normally.
REQ-022 rvalid toggling 1,0,1,0 -> exactly 32 pulses, each 1 cycle after its handshake; data order preserved.
REQ-023 rresp=2'b10 on beat 5 -> err=1 from the next cycle and stays 1; all 32 beats are forwarded.
REQ-024 rlast=1 on beat 10 -> mem_last on beat 10, err=1, FSM in DONE; miss=0 -> IDLE, refill_cnt incremented.
REQ-025 reset pulsed after beat 12 -> all outputs at reset values next cycle; remaining rvalid beats are ignored; a new miss at 0x0000_2080 -> araddr=0x0000_2080.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Cache line refill controller: issues one AXI INCR read burst per miss and streams
// each returned beat to the cache as a one-cycle write pulse.
module cache_refill_ctrl #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINE_SIZE_BITS = 7
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    miss,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_in,
    output logic [DATA_WIDTH/8-1:0] mem_wstb,
    output logic                    mem_data_valid,
    output logic                    mem_last,
    output logic                    busy,
    output logic                    err,
    output logic [15:0]             refill_cnt
);

    localparam int unsigned BYTES     = DATA_WIDTH / 8;
    localparam int unsigned BEATS     = (1 << LINE_SIZE_BITS) / BYTES;
    localparam int unsigned SIZE_LOG2 = $clog2(BYTES);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        ~ADDR_WIDTH'((64'd1 << LINE_SIZE_BITS) - 64'd1);
    localparam logic [LINE_SIZE_BITS-1:0] LAST_BEAT = LINE_SIZE_BITS'(BEATS - 1);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_t;

    state_t                    r_state;
    logic [ADDR_WIDTH-1:0]     r_line_base;
    logic [LINE_SIZE_BITS-1:0] r_beat;
    logic                      r_arvalid;
    logic                      r_rready;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [DATA_WIDTH-1:0]     r_mem_data_in;
    logic [BYTES-1:0]          r_mem_wstb;
    logic                      r_mem_data_valid;
    logic                      r_mem_last;
    logic                      r_err;
    logic [15:0]               r_refill_cnt;

    logic [ADDR_WIDTH-1:0]     w_beat_addr;
    logic                      w_final_beat;
    logic                      w_beat_err;

    assign w_beat_addr  = r_line_base + (ADDR_WIDTH'(r_beat) << SIZE_LOG2);
    // The burst ends on whichever comes first: the counted last beat or the slave's rlast.
    assign w_final_beat = (r_beat == LAST_BEAT) || rlast;
    assign w_beat_err   = (rresp != 2'b00)
                        || (rlast && (r_beat != LAST_BEAT))
                        || (!rlast && (r_beat == LAST_BEAT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= StIdle;
            r_line_base      <= '0;
            r_beat           <= '0;
            r_arvalid        <= 1'b0;
            r_rready         <= 1'b0;
            r_mem_addr       <= '0;
            r_mem_data_in    <= '0;
            r_mem_wstb       <= '0;
            r_mem_data_valid <= 1'b0;
            r_mem_last       <= 1'b0;
            r_err            <= 1'b0;
            r_refill_cnt     <= '0;
        end else begin
            r_mem_data_valid <= 1'b0;
            r_mem_last       <= 1'b0;
            r_mem_wstb       <= '0;
            unique case (r_state)
                StIdle: begin
                    if (miss) begin
                        r_line_base <= cpu_addr & LINE_MASK;
                        r_beat      <= '0;
                        r_arvalid   <= 1'b1;
                        r_state     <= StAddr;
                    end
                end
                StAddr: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= StData;
                    end
                end
                StData: begin
                    if (rvalid) begin
                        r_mem_data_in    <= rdata;
                        r_mem_addr       <= w_beat_addr;
                        r_mem_wstb       <= '1;
                        r_mem_data_valid <= 1'b1;
                        r_beat           <= r_beat + 1'b1;
                        if (w_beat_err) begin
                            r_err <= 1'b1;
                        end
                        if (w_final_beat) begin
                            r_mem_last <= 1'b1;
                            r_rready   <= 1'b0;
                            r_state    <= StDone;
                        end
                    end
                end
                StDone: begin
                    // Wait for the cache to drop miss so one miss never launches two bursts.
                    if (!miss) begin
                        if (r_refill_cnt != 16'hFFFF) begin
                            r_refill_cnt <= r_refill_cnt + 16'd1;
                        end
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign arvalid        = r_arvalid;
    assign araddr         = r_line_base;
    assign arlen          = 8'(BEATS - 1);
    assign arsize         = 3'(SIZE_LOG2);
    assign arburst        = 2'b01;
    assign rready         = r_rready;
    assign mem_addr       = r_mem_addr;
    assign mem_data_in    = r_mem_data_in;
    assign mem_wstb       = r_mem_wstb;
    assign mem_data_valid = r_mem_data_valid;
    assign mem_last       = r_mem_last;
    assign busy           = (r_state != StIdle);
    assign err            = r_err;
    assign refill_cnt     = r_refill_cnt;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomised self-checking bench for cache_refill_ctrl; expected beats come from a
// line/beat arithmetic model, not from the controller's state machine.
module tb_cache_refill_ctrl;

    localparam int BEATS      = 32;
    localparam int LINE_BYTES = 128;

    logic        clk = 1'b0;
    logic        reset, miss, arvalid, arready, rvalid, rready, rlast;
    logic        mem_data_valid, mem_last, busy, err;
    logic [31:0] cpu_addr, araddr, rdata, mem_addr, mem_data_in;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic [3:0]  mem_wstb;
    logic [15:0] refill_cnt;

    cache_refill_ctrl #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .LINE_SIZE_BITS (7)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .miss           (miss),
        .cpu_addr       (cpu_addr),
        .arvalid        (arvalid),
        .arready        (arready),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_wstb       (mem_wstb),
        .mem_data_valid (mem_data_valid),
        .mem_last       (mem_last),
        .busy           (busy),
        .err            (err),
        .refill_cnt     (refill_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    bit exp_err  = 1'b0;

    logic [31:0] beat_data [BEATS];

    logic [31:0] obs_araddr;
    logic [7:0]  obs_arlen;
    logic [2:0]  obs_arsize;
    logic [1:0]  obs_arburst;
    int          obs_ar_cycles, obs_ar_unstable, obs_lat_bad, obs_wstb_bad, obs_err_at;
    int          obs_done_bad;
    bit          obs_timeout;
    logic [15:0] obs_cnt;
    logic        obs_busy;
    logic [31:0] obs_addr [$];
    logic [31:0] obs_data [$];
    bit          obs_last [$];
    logic [31:0] exp_addr [$];
    logic [31:0] exp_data [$];
    bit          exp_last [$];

    // Reference model: line base, byte address and last flag per beat, plus sticky error.
    task automatic build_model(input logic [31:0] addr, input int rlast_at, input int bad_at,
                               input int nsend);
        logic [31:0] base;
        base = (addr / LINE_BYTES) * LINE_BYTES;
        exp_addr.delete();
        exp_data.delete();
        exp_last.delete();
        for (int k = 0; k < nsend; k++) begin
            exp_addr.push_back(base + 32'(4 * k));
            exp_data.push_back(beat_data[k]);
            exp_last.push_back((k == BEATS - 1) || (k == rlast_at));
            if (k == bad_at) exp_err = 1'b1;
            if (k == rlast_at && k < BEATS - 1) exp_err = 1'b1;
            if (k == BEATS - 1 && rlast_at != k) exp_err = 1'b1;
        end
    endtask

    task automatic fill_data(input bit use_index);
        for (int k = 0; k < BEATS; k++) beat_data[k] = use_index ? 32'(k) : $urandom;
    endtask

    task automatic apply_reset();
        reset   = 1'b1;
        miss    = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        @(posedge clk); #1;
        reset   = 1'b0;
        exp_cnt = 0;
        exp_err = 1'b0;
    endtask

    // Drives one miss: AR handshake after ar_stall refusals, then nsend R beats.
    // gap_mode 0 = back-to-back, 1 = alternate cycles, 2 = random gaps.
    task automatic drive_burst(input logic [31:0] addr, input int ar_stall, input int gap_mode,
                               input int rlast_at, input int bad_at, input int nsend);
        int g, k, stall;
        bit tog, hs, want;
        obs_addr.delete();
        obs_data.delete();
        obs_last.delete();
        obs_ar_cycles = 0; obs_ar_unstable = 0; obs_lat_bad = 0; obs_wstb_bad = 0;
        obs_err_at = -1; obs_timeout = 1'b0;
        miss = 1'b1; cpu_addr = addr; arready = 1'b0;
        @(posedge clk); #1;
        cpu_addr = $urandom;
        g = 0;
        while (!arvalid && g < 10) begin @(posedge clk); #1; g++; end
        if (arvalid !== 1'b1) begin obs_timeout = 1'b1; return; end
        obs_araddr = araddr; obs_arlen = arlen; obs_arsize = arsize; obs_arburst = arburst;
        stall = ar_stall; g = 0;
        while (arvalid === 1'b1 && g < 100) begin
            if (araddr !== obs_araddr || arlen !== obs_arlen || arsize !== obs_arsize
                || arburst !== obs_arburst || rready !== 1'b0) obs_ar_unstable++;
            obs_ar_cycles++;
            arready = (stall == 0);
            if (stall > 0) stall--;
            cpu_addr = $urandom;
            @(posedge clk); #1; g++;
        end
        arready = 1'b0;
        if (arvalid !== 1'b0) begin obs_timeout = 1'b1; return; end
        k = 0; tog = 1'b1; g = 0;
        while (k < nsend && g < 400) begin
            case (gap_mode)
                0:       want = 1'b1;
                1:       want = tog;
                default: want = 1'($urandom_range(0, 1));
            endcase
            tog = !tog;
            if (want) begin
                rvalid = 1'b1; rdata = beat_data[k];
                rresp = (k == bad_at) ? 2'b10 : 2'b00; rlast = (k == rlast_at);
            end else begin
                rvalid = 1'b0; rdata = $urandom; rresp = 2'($urandom); rlast = 1'($urandom);
            end
            hs = rvalid && (rready === 1'b1);
            @(posedge clk); #1; g++;
            if (mem_data_valid !== hs) obs_lat_bad++;
            if (mem_last === 1'b1 && mem_data_valid !== 1'b1) obs_lat_bad++;
            if (mem_wstb !== (mem_data_valid === 1'b1 ? 4'hF : 4'h0)) obs_wstb_bad++;
            if (mem_data_valid === 1'b1) begin
                obs_addr.push_back(mem_addr);
                obs_data.push_back(mem_data_in);
                obs_last.push_back(mem_last === 1'b1);
            end
            if (err === 1'b1 && obs_err_at == -1) obs_err_at = hs ? k : 1000;
            if (hs) k++;
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
        if (k < nsend) obs_timeout = 1'b1;
    endtask

    // Holds miss in DONE with stray R beats offered, then drops miss.
    task automatic end_refill(input int hold);
        obs_done_bad = 0;
        for (int i = 0; i < hold; i++) begin
            rvalid = 1'($urandom); rdata = $urandom; rlast = 1'($urandom);
            @(posedge clk); #1;
            if (arvalid !== 1'b0 || busy !== 1'b1 || rready !== 1'b0
                || mem_data_valid !== 1'b0) obs_done_bad++;
        end
        rvalid = 1'b0; rlast = 1'b0;
        miss = 1'b0;
        @(posedge clk); #1;
        obs_cnt  = refill_cnt;
        obs_busy = busy;
        exp_cnt  = (exp_cnt == 65535) ? 65535 : exp_cnt + 1;
    endtask

    task automatic test_reset();
        reset = 1'b1; miss = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
        rresp = 2'b00; rdata = '0; cpu_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({arvalid, rready, mem_data_valid, mem_last, busy, err} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {arvalid, rready, mem_data_valid, mem_last, busy, err});
        end
        n_checks++;
        if (mem_addr !== 32'h0 || mem_data_in !== 32'h0 || mem_wstb !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got addr %h data %h wstb %h expected zeros",
                     mem_addr, mem_data_in, mem_wstb);
        end
        n_checks++;
        if (refill_cnt !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt: got %0d expected 0", refill_cnt);
        end
        reset = 1'b0; exp_cnt = 0; exp_err = 1'b0;
    endtask

    task automatic test_basic_refill();
        int bad;
        fill_data(1'b1);
        build_model(32'h0000_1234, 31, -1, 32);
        drive_burst(32'h0000_1234, 0, 0, 31, -1, 32);
        n_checks++;
        if (obs_araddr !== 32'h1200 || obs_arlen !== 8'd31 || obs_arsize !== 3'd2
            || obs_arburst !== 2'b01) begin
            n_fail++;
            $display("FAIL basic_ar: got addr %h len %0d size %0d burst %0d expected 1200 31 2 1",
                     obs_araddr, obs_arlen, obs_arsize, obs_arburst);
        end
        n_checks++;
        if (obs_timeout || obs_addr.size() != 32) begin
            n_fail++;
            $display("FAIL basic_count: got %0d beats (timeout %0b) expected 32",
                     obs_addr.size(), obs_timeout);
        end
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]
                || obs_last[i] !== exp_last[i]) bad++;
        n_checks++;
        if (bad != 0 || obs_lat_bad != 0 || obs_wstb_bad != 0) begin
            n_fail++;
            $display("FAIL basic_beats: got %0d beat/%0d pulse/%0d wstb errors expected 0",
                     bad, obs_lat_bad, obs_wstb_bad);
        end
        end_refill(3);
        n_checks++;
        if (obs_done_bad != 0 || obs_cnt !== 16'(exp_cnt) || obs_busy !== 1'b0
            || err !== exp_err) begin
            n_fail++;
            $display("FAIL basic_done: got done_bad %0d cnt %0d busy %b err %b expected 0 %0d 0 %b",
                     obs_done_bad, obs_cnt, obs_busy, err, exp_cnt, exp_err);
        end
    endtask

    task automatic test_arready_stall();
        int bad;
        logic [31:0] a;
        a = $urandom;
        fill_data(1'b0);
        build_model(a, 31, -1, 32);
        drive_burst(a, 3, 0, 31, -1, 32);
        n_checks++;
        if (obs_ar_cycles != 4 || obs_ar_unstable != 0 || obs_araddr !== exp_addr[0]) begin
            n_fail++;
            $display("FAIL stall_ar: got %0d cycles %0d unstable addr %h expected 4 0 %h",
                     obs_ar_cycles, obs_ar_unstable, obs_araddr, exp_addr[0]);
        end
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]
                || obs_last[i] !== exp_last[i]) bad++;
        n_checks++;
        if (obs_timeout || obs_addr.size() != 32 || bad != 0 || obs_lat_bad != 0) begin
            n_fail++;
            $display("FAIL stall_beats: got %0d beats %0d bad %0d late expected 32 0 0",
                     obs_addr.size(), bad, obs_lat_bad);
        end
        end_refill(1);
        n_checks++;
        if (obs_cnt !== 16'(exp_cnt)) begin
            n_fail++; $display("FAIL stall_cnt: got %0d expected %0d", obs_cnt, exp_cnt);
        end
    endtask

    task automatic test_rvalid_gaps();
        int bad;
        logic [31:0] a;
        a = $urandom;
        fill_data(1'b0);
        build_model(a, 31, -1, 32);
        drive_burst(a, 1, 1, 31, -1, 32);
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]
                || obs_last[i] !== exp_last[i]) bad++;
        n_checks++;
        if (obs_timeout || obs_addr.size() != 32 || bad != 0) begin
            n_fail++;
            $display("FAIL gaps_beats: got %0d beats %0d bad expected 32 0", obs_addr.size(), bad);
        end
        n_checks++;
        if (obs_lat_bad != 0 || obs_wstb_bad != 0) begin
            n_fail++;
            $display("FAIL gaps_pulse: got %0d pulse %0d wstb errors expected 0",
                     obs_lat_bad, obs_wstb_bad);
        end
        end_refill(2);
    endtask

    task automatic test_rresp_error();
        int bad;
        apply_reset();
        fill_data(1'b0);
        build_model(32'h0000_4400, 31, 5, 32);
        drive_burst(32'h0000_4400, 0, 0, 31, 5, 32);
        n_checks++;
        if (obs_err_at != 5) begin
            n_fail++; $display("FAIL rresp_err_timing: got beat %0d expected 5", obs_err_at);
        end
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
        n_checks++;
        if (obs_addr.size() != 32 || bad != 0) begin
            n_fail++;
            $display("FAIL rresp_forward: got %0d beats %0d bad expected 32 0",
                     obs_addr.size(), bad);
        end
        end_refill(2);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL rresp_sticky: got err %b expected 1", err);
        end
    endtask

    task automatic test_early_rlast();
        int bad;
        apply_reset();
        fill_data(1'b0);
        build_model(32'h0000_5A10, 10, -1, 11);
        drive_burst(32'h0000_5A10, 0, 2, 10, -1, 11);
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]
                || obs_last[i] !== exp_last[i]) bad++;
        n_checks++;
        if (obs_timeout || obs_addr.size() != 11 || bad != 0 || obs_err_at != 10) begin
            n_fail++;
            $display("FAIL early_rlast_beats: got %0d beats %0d bad err_at %0d expected 11 0 10",
                     obs_addr.size(), bad, obs_err_at);
        end
        end_refill(4);
        n_checks++;
        if (obs_done_bad != 0 || obs_cnt !== 16'(exp_cnt) || obs_busy !== 1'b0
            || err !== 1'b1) begin
            n_fail++;
            $display("FAIL early_rlast_done: got done_bad %0d cnt %0d busy %b err %b expected 0 %0d 0 1",
                     obs_done_bad, obs_cnt, obs_busy, err, exp_cnt);
        end
    endtask

    task automatic test_missing_rlast();
        apply_reset();
        fill_data(1'b0);
        build_model(32'h0000_6000, 99, -1, 32);
        drive_burst(32'h0000_6000, 0, 0, 99, -1, 32);
        n_checks++;
        if (obs_addr.size() != 32 || obs_last.size() != 32 || obs_last[31] !== 1'b1
            || obs_err_at != 31) begin
            n_fail++;
            $display("FAIL missing_rlast: got %0d beats err_at %0d expected 32 31",
                     obs_addr.size(), obs_err_at);
        end
        end_refill(1);
    endtask

    task automatic test_mid_reset();
        int bad;
        apply_reset();
        fill_data(1'b0);
        drive_burst(32'h0000_3344, 0, 0, 31, -1, 13);
        reset = 1'b1; rvalid = 1'b1; rdata = $urandom;
        @(posedge clk); #1;
        n_checks++;
        if ({arvalid, rready, mem_data_valid, mem_last, busy, err} !== 6'b0
            || mem_addr !== 32'h0 || mem_data_in !== 32'h0 || mem_wstb !== 4'h0
            || refill_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got flags %b addr %h data %h cnt %0d expected zeros",
                     {arvalid, rready, mem_data_valid, mem_last, busy, err},
                     mem_addr, mem_data_in, refill_cnt);
        end
        reset = 1'b0; miss = 1'b0; exp_cnt = 0; exp_err = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1; rdata = $urandom; rlast = 1'($urandom);
            @(posedge clk); #1;
            if (mem_data_valid !== 1'b0 || rready !== 1'b0 || arvalid !== 1'b0) bad++;
        end
        rvalid = 1'b0; rlast = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL midreset_ignore: got %0d bad cycles expected 0", bad);
        end
        fill_data(1'b0);
        build_model(32'h0000_2080, 31, -1, 32);
        drive_burst(32'h0000_2080, 0, 0, 31, -1, 32);
        bad = 0;
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
            if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]) bad++;
        n_checks++;
        if (obs_araddr !== 32'h0000_2080 || obs_addr.size() != 32 || bad != 0) begin
            n_fail++;
            $display("FAIL midreset_fresh: got araddr %h %0d beats %0d bad expected 2080 32 0",
                     obs_araddr, obs_addr.size(), bad);
        end
        end_refill(1);
        n_checks++;
        if (obs_cnt !== 16'd1) begin
            n_fail++; $display("FAIL midreset_cnt: got %0d expected 1", obs_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int bad, bad_at, rl_at, nsend;
        logic [31:0] a;
        apply_reset();
        for (int r = 0; r < 6; r++) begin
            a      = $urandom;
            bad_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1;
            rl_at  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 30)) : 31;
            nsend  = rl_at + 1;
            fill_data(1'b0);
            build_model(a, rl_at, bad_at, nsend);
            drive_burst(a, int'($urandom_range(0, 3)), 2, rl_at, bad_at, nsend);
            bad = 0;
            for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++)
                if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i]
                    || obs_last[i] !== exp_last[i]) bad++;
            n_checks++;
            if (obs_timeout || obs_addr.size() != exp_addr.size() || bad != 0
                || obs_lat_bad != 0 || obs_araddr !== exp_addr[0]) begin
                n_fail++;
                $display("FAIL random_burst%0d: got %0d beats %0d bad %0d late araddr %h expected %0d 0 0 %h",
                         r, obs_addr.size(), bad, obs_lat_bad, obs_araddr, exp_addr.size(),
                         exp_addr[0]);
            end
            end_refill(int'($urandom_range(0, 3)));
            n_checks++;
            if (obs_cnt !== 16'(exp_cnt) || err !== exp_err) begin
                n_fail++;
                $display("FAIL random_done%0d: got cnt %0d err %b expected %0d %b",
                         r, obs_cnt, err, exp_cnt, exp_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_refill();
        test_arready_stall();
        test_rvalid_gaps();
        test_rresp_error();
        test_early_rlast();
        test_missing_rlast();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
